apb_cmd_master: RTL and testbench
=================================

Name: apb_cmd_master

Overview:
- APB initiator that turns a simple valid/ready command stream into single APB3 transfers.
- Returns each result on a valid/ready response stream.
- Sits between a controller or debug bridge and the subsystem APB ports. Drives PADDR/PSEL/PENABLE/PWRITE/PWDATA and samples PRDATA/PREADY/PSLVERR.
- Includes a wait-state timeout, so a stalled slave (PREADY tied 0) cannot hang the initiator.

Parameters:
- ADDR_W, 32, width of cmd_addr and PADDR.
- DATA_W, 32, width of write/read data.
- TIMEOUT_CYCLES, 255, max ACCESS cycles with PREADY low before abort; 0 disables timeout.

Ports:
- clk_in  input  1  single clock, all logic rising-edge.
- reset_int  input  1  synchronous active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  command accepted when cmd_valid&cmd_ready.
- cmd_write  input  1  1=write, 0=read.
- cmd_addr  input  ADDR_W  transfer address.
- cmd_wdata  input  DATA_W  write data.
- rsp_valid  output  1  response present.
- rsp_ready  input  1  response consumed when rsp_valid&rsp_ready.
- rsp_rdata  output  DATA_W  read data; 0 for writes and timeouts.
- rsp_err  output  1  PSLVERR seen, or timeout.
- rsp_timeout  output  1  transfer aborted by timeout.
- PADDR  output  ADDR_W  APB address.
- PSEL  output  1  APB select.
- PENABLE  output  1  APB enable.
- PWRITE  output  1  APB direction.
- PWDATA  output  DATA_W  APB write data.
- PRDATA  input  DATA_W  APB read data.
- PREADY  input  1  APB ready.
- PSLVERR  input  1  APB error.

Behaviour:
- FSM states: IDLE, SETUP, ACCESS, RESP. Reset state is IDLE.
- Reset values: all outputs 0. This includes PADDR, PWDATA, PWRITE, rsp_rdata, rsp_err and rsp_timeout. cmd_ready is 1 one cycle after reset release (combinational state==IDLE, gated low while reset_int=1).
- IDLE:
  - cmd_ready=1.
  - On cmd_valid: register addr/wdata/write into PADDR/PWDATA/PWRITE and go to SETUP.
- SETUP:
  - PSEL=1, PENABLE=0.
  - Always go to ACCESS next cycle.
- ACCESS:
  - PSEL=1, PENABLE=1.
  - Wait counter clears on entry and increments each ACCESS cycle with PREADY=0.
  - If PREADY=1: capture rsp_rdata=PRDATA on a read (0 on a write), rsp_err=PSLVERR, rsp_timeout=0. Go to RESP.
  - If PREADY=0 and TIMEOUT_CYCLES!=0 and ACCESS has lasted TIMEOUT_CYCLES cycles: abort. Set rsp_rdata=0, rsp_err=1, rsp_timeout=1 and go to RESP.
  - PREADY=1 in the abort cycle wins: normal completion.
- RESP:
  - PSEL=0, PENABLE=0, rsp_valid=1.
  - Response fields stay stable until rsp_ready. On rsp_ready, go to IDLE.
  - No new command is accepted in the same cycle; one outstanding transfer max.
- PADDR/PWDATA/PWRITE are stable from SETUP through the end of ACCESS. They keep their last values in IDLE/RESP.
- Latency with zero wait states and rsp_ready=1:
  - accept at cycle t;
  - SETUP t+1;
  - ACCESS t+2;
  - rsp_valid t+3;
  - cmd_ready t+4.
- Each wait state adds one cycle.
- Counter width is ceil(log2(TIMEOUT_CYCLES+1)) bits and never wraps. It saturates at abort.
- PRDATA/PSLVERR are sampled only in an ACCESS cycle with PREADY=1. They are ignored at all other times.
- reset_int asserted in any state, including mid-ACCESS or RESP with a pending response:
  - next cycle is IDLE with all outputs 0;
  - the transfer is dropped with no response;
  - PSEL falls the cycle after reset is sampled.

Test Plan:
- Zero-wait read: cmd read addr 0x0000_0104, PREADY=1, PRDATA=0xDEAD_BEEF -> PSEL high cycles t+1..t+2, PENABLE high t+2 only; rsp_valid at t+3 with rdata 0xDEAD_BEEF, err=0, timeout=0.
- Write with 3 wait states: addr 0x10, wdata 0x1234_5678, PREADY low for 3 ACCESS cycles -> PADDR/PWDATA/PWRITE=1 stable for 5 cycles; rsp at t+6, rdata=0, err=0.
- Slave error: read, PREADY=1 with PSLVERR=1, PRDATA=0xA5 -> rsp_err=1, rsp_timeout=0, rsp_rdata=0xA5.
- Timeout against tied-off slave (PREADY=0), TIMEOUT_CYCLES=8 -> exactly 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rdata=0; PSEL drops. Repeat with PREADY=1 on the 8th cycle -> normal completion.
- Backpressure: rsp_ready held 0 for 10 cycles -> rsp_valid and fields stable, cmd_ready=0, PSEL=0 throughout; release -> IDLE next cycle; back-to-back second command accepted then.
- Reset mid-ACCESS with PREADY=0: assert reset_int 1 cycle -> next cycle PSEL=PENABLE=0, all outputs 0, no rsp_valid; a new command after release completes normally.

Source files
------------

// File: rtl/apb_cmd_master.sv
// APB3 initiator: one valid/ready command becomes one APB transfer and one response.
// Latency: accept t, SETUP t+1, ACCESS t+2 (+1 per wait state), response valid t+3.
// Backpressure: a held response blocks new commands; one transfer outstanding at most.
module apb_cmd_master #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk_in,
    input  logic              reset_int,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    output logic [ADDR_W-1:0] PADDR,
    output logic              PSEL,
    output logic              PENABLE,
    output logic              PWRITE,
    output logic [DATA_W-1:0] PWDATA,
    input  logic [DATA_W-1:0] PRDATA,
    input  logic              PREADY,
    input  logic              PSLVERR
);

    localparam bit TO_EN = (TIMEOUT_CYCLES != 0);
    localparam int CNT_W = TO_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TO_EN ? TIMEOUT_CYCLES - 1 : 0);

    typedef enum logic [1:0] {
        IDLE,
        SETUP,
        ACCESS,
        RESP
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             done;
    logic             abort;

    always_ff @(posedge clk_in) begin
        if (reset_int) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        PSEL      = 1'b0;
        PENABLE   = 1'b0;
        rsp_valid = 1'b0;
        accept    = 1'b0;
        done      = 1'b0;
        abort     = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = !reset_int;
                if (cmd_valid && !reset_int) begin
                    accept    = 1'b1;
                    state_nxt = SETUP;
                end
            end
            SETUP: begin
                PSEL      = 1'b1;
                state_nxt = ACCESS;
            end
            ACCESS: begin
                PSEL    = 1'b1;
                PENABLE = 1'b1;
                // A ready slave in the final wait cycle still completes normally.
                if (PREADY) begin
                    done      = 1'b1;
                    state_nxt = RESP;
                end else if (TO_EN && (wait_cnt == CNT_LAST)) begin
                    abort     = 1'b1;
                    state_nxt = RESP;
                end
            end
            RESP: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_in) begin
        if (reset_int) begin
            PADDR       <= '0;
            PWDATA      <= '0;
            PWRITE      <= 1'b0;
            wait_cnt    <= '0;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            if (accept) begin
                PADDR  <= cmd_addr;
                PWDATA <= cmd_wdata;
                PWRITE <= cmd_write;
            end
            // Counter tops out at TIMEOUT_CYCLES on the abort cycle, so it never wraps.
            if (state == SETUP) begin
                wait_cnt <= '0;
            end else if (TO_EN && (state == ACCESS) && !PREADY) begin
                wait_cnt <= wait_cnt + CNT_W'(1);
            end
            if (done) begin
                rsp_rdata   <= PWRITE ? '0 : PRDATA;
                rsp_err     <= PSLVERR;
                rsp_timeout <= 1'b0;
            end else if (abort) begin
                rsp_rdata   <= '0;
                rsp_err     <= 1'b1;
                rsp_timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_apb_cmd_master.sv
// Directed bench for apb_cmd_master with an 8-cycle wait-state timeout.
module tb_apb_cmd_master;

    logic        clk_in = 1'b0;
    logic        reset_int;
    logic        cmd_valid;
    logic        cmd_ready;
    logic        cmd_write;
    logic [31:0] cmd_addr;
    logic [31:0] cmd_wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic        rsp_err;
    logic        rsp_timeout;
    logic [31:0] PADDR;
    logic        PSEL;
    logic        PENABLE;
    logic        PWRITE;
    logic [31:0] PWDATA;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;

    int checks = 0;
    int errors = 0;

    apb_cmd_master #(
        .ADDR_W(32),
        .DATA_W(32),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk_in(clk_in),
        .reset_int(reset_int),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_write(cmd_write),
        .cmd_addr(cmd_addr),
        .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err),
        .rsp_timeout(rsp_timeout),
        .PADDR(PADDR),
        .PSEL(PSEL),
        .PENABLE(PENABLE),
        .PWRITE(PWRITE),
        .PWDATA(PWDATA),
        .PRDATA(PRDATA),
        .PREADY(PREADY),
        .PSLVERR(PSLVERR)
    );

    always #5 clk_in = ~clk_in;

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    task automatic chk_word(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Presents one command in IDLE and leaves the bench in the SETUP cycle.
    task automatic issue(input logic wr, input logic [31:0] addr, input logic [31:0] wdata);
        cmd_write = wr;
        cmd_addr  = addr;
        cmd_wdata = wdata;
        cmd_valid = 1'b1;
        chk_bit("issue_cmd_ready", cmd_ready, 1'b1);
        tick();
        cmd_valid = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk_bit({tag, "_psel"}, PSEL, 1'b0);
        chk_bit({tag, "_penable"}, PENABLE, 1'b0);
        chk_bit({tag, "_pwrite"}, PWRITE, 1'b0);
        chk_word({tag, "_paddr"}, PADDR, 32'h0);
        chk_word({tag, "_pwdata"}, PWDATA, 32'h0);
        chk_bit({tag, "_rsp_valid"}, rsp_valid, 1'b0);
        chk_word({tag, "_rsp_rdata"}, rsp_rdata, 32'h0);
        chk_bit({tag, "_rsp_err"}, rsp_err, 1'b0);
        chk_bit({tag, "_rsp_timeout"}, rsp_timeout, 1'b0);
        chk_bit({tag, "_cmd_ready"}, cmd_ready, 1'b0);
    endtask

    initial begin
        reset_int = 1'b1;
        cmd_valid = 1'b0;
        cmd_write = 1'b0;
        cmd_addr  = 32'h0;
        cmd_wdata = 32'h0;
        rsp_ready = 1'b1;
        PRDATA    = 32'h0;
        PREADY    = 1'b0;
        PSLVERR   = 1'b0;
        tick();
        tick();
        chk_all_zero("reset");
        reset_int = 1'b0;
        tick();
        chk_bit("post_reset_cmd_ready", cmd_ready, 1'b1);

        // Zero-wait read
        PREADY = 1'b1;
        PRDATA = 32'hDEAD_BEEF;
        issue(1'b0, 32'h0000_0104, 32'h0);
        chk_bit("rd_setup_psel", PSEL, 1'b1);
        chk_bit("rd_setup_penable", PENABLE, 1'b0);
        chk_word("rd_setup_paddr", PADDR, 32'h0000_0104);
        chk_bit("rd_setup_pwrite", PWRITE, 1'b0);
        chk_bit("rd_setup_cmd_ready", cmd_ready, 1'b0);
        tick();
        chk_bit("rd_access_psel", PSEL, 1'b1);
        chk_bit("rd_access_penable", PENABLE, 1'b1);
        chk_bit("rd_access_rsp_valid", rsp_valid, 1'b0);
        tick();
        chk_bit("rd_rsp_valid", rsp_valid, 1'b1);
        chk_bit("rd_rsp_psel", PSEL, 1'b0);
        chk_bit("rd_rsp_penable", PENABLE, 1'b0);
        chk_word("rd_rsp_rdata", rsp_rdata, 32'hDEAD_BEEF);
        chk_bit("rd_rsp_err", rsp_err, 1'b0);
        chk_bit("rd_rsp_timeout", rsp_timeout, 1'b0);
        tick();
        chk_bit("rd_done_cmd_ready", cmd_ready, 1'b1);
        chk_bit("rd_done_rsp_valid", rsp_valid, 1'b0);

        // Write with three wait states
        PREADY = 1'b0;
        issue(1'b1, 32'h0000_0010, 32'h1234_5678);
        for (int i = 0; i < 5; i++) begin
            if (i == 4) PREADY = 1'b1;
            chk_bit("wr_psel", PSEL, 1'b1);
            chk_bit("wr_penable", PENABLE, (i != 0));
            chk_word("wr_paddr", PADDR, 32'h0000_0010);
            chk_word("wr_pwdata", PWDATA, 32'h1234_5678);
            chk_bit("wr_pwrite", PWRITE, 1'b1);
            chk_bit("wr_rsp_valid_early", rsp_valid, 1'b0);
            tick();
        end
        PREADY = 1'b0;
        chk_bit("wr_rsp_valid", rsp_valid, 1'b1);
        chk_word("wr_rsp_rdata", rsp_rdata, 32'h0);
        chk_bit("wr_rsp_err", rsp_err, 1'b0);
        chk_bit("wr_rsp_timeout", rsp_timeout, 1'b0);
        tick();

        // Slave error on a read
        PREADY  = 1'b1;
        PSLVERR = 1'b1;
        PRDATA  = 32'h0000_00A5;
        issue(1'b0, 32'h0000_0020, 32'h0);
        tick();
        tick();
        PSLVERR = 1'b0;
        chk_bit("err_rsp_valid", rsp_valid, 1'b1);
        chk_bit("err_rsp_err", rsp_err, 1'b1);
        chk_bit("err_rsp_timeout", rsp_timeout, 1'b0);
        chk_word("err_rsp_rdata", rsp_rdata, 32'h0000_00A5);
        tick();

        // Timeout against a slave that never becomes ready
        PREADY = 1'b0;
        PRDATA = 32'hFFFF_FFFF;
        issue(1'b0, 32'h0000_0030, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            chk_bit("to_access_penable", PENABLE, 1'b1);
            tick();
        end
        chk_bit("to_rsp_valid", rsp_valid, 1'b1);
        chk_bit("to_psel_drop", PSEL, 1'b0);
        chk_bit("to_penable_drop", PENABLE, 1'b0);
        chk_bit("to_rsp_err", rsp_err, 1'b1);
        chk_bit("to_rsp_timeout", rsp_timeout, 1'b1);
        chk_word("to_rsp_rdata", rsp_rdata, 32'h0);
        tick();

        // Ready arriving in the eighth ACCESS cycle completes normally
        PRDATA = 32'h0000_55AA;
        issue(1'b0, 32'h0000_0034, 32'h0);
        tick();
        for (int i = 0; i < 8; i++) begin
            if (i == 7) PREADY = 1'b1;
            chk_bit("to8_access_penable", PENABLE, 1'b1);
            tick();
        end
        PREADY = 1'b0;
        chk_bit("to8_rsp_valid", rsp_valid, 1'b1);
        chk_bit("to8_rsp_err", rsp_err, 1'b0);
        chk_bit("to8_rsp_timeout", rsp_timeout, 1'b0);
        chk_word("to8_rsp_rdata", rsp_rdata, 32'h0000_55AA);
        tick();

        // Response backpressure, then a back-to-back command
        PREADY    = 1'b1;
        PRDATA    = 32'h0000_0077;
        rsp_ready = 1'b0;
        issue(1'b0, 32'h0000_0040, 32'h0);
        tick();
        tick();
        for (int i = 0; i < 10; i++) begin
            PRDATA = 32'h1000_0000 + 32'(i);
            chk_bit("bp_rsp_valid", rsp_valid, 1'b1);
            chk_word("bp_rsp_rdata", rsp_rdata, 32'h0000_0077);
            chk_bit("bp_rsp_err", rsp_err, 1'b0);
            chk_bit("bp_cmd_ready", cmd_ready, 1'b0);
            chk_bit("bp_psel", PSEL, 1'b0);
            tick();
        end
        rsp_ready = 1'b1;
        chk_bit("bp_release_rsp_valid", rsp_valid, 1'b1);
        tick();
        chk_bit("bp_idle_rsp_valid", rsp_valid, 1'b0);
        issue(1'b1, 32'h0000_0044, 32'hCAFE_F00D);
        chk_word("b2b_pwdata", PWDATA, 32'hCAFE_F00D);
        tick();
        tick();
        chk_bit("b2b_rsp_valid", rsp_valid, 1'b1);
        chk_word("b2b_rsp_rdata", rsp_rdata, 32'h0);
        tick();

        // Reset in the middle of a stalled ACCESS
        PREADY = 1'b0;
        issue(1'b0, 32'h0000_0050, 32'h0000_FFFF);
        tick();
        chk_bit("rst_pre_penable", PENABLE, 1'b1);
        reset_int = 1'b1;
        tick();
        chk_all_zero("rst_mid");
        reset_int = 1'b0;
        tick();
        chk_bit("rst_after_rsp_valid", rsp_valid, 1'b0);
        chk_bit("rst_after_cmd_ready", cmd_ready, 1'b1);
        PREADY = 1'b1;
        PRDATA = 32'h0000_0099;
        issue(1'b0, 32'h0000_0060, 32'h0);
        chk_word("rst_new_paddr", PADDR, 32'h0000_0060);
        tick();
        tick();
        chk_bit("rst_new_rsp_valid", rsp_valid, 1'b1);
        chk_word("rst_new_rsp_rdata", rsp_rdata, 32'h0000_0099);
        tick();
        chk_bit("rst_new_idle", cmd_ready, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
